// File: rtl/riscv_custom_instr_wrapper_pkg.sv
// Shared types for the custom-instruction wrapper: RVG major opcodes,
// controller state enum and the step-table record.
package RISCVCustomInstrWrapperTypes;

    localparam logic [4:0] RVG_LOAD      = 5'd0;
    localparam logic [4:0] RVG_LOAD_FP   = 5'd1;
    localparam logic [4:0] RVG_custom_0  = 5'd2;
    localparam logic [4:0] RVG_MISC_MEM  = 5'd3;
    localparam logic [4:0] RVG_OP_IMM    = 5'd4;
    localparam logic [4:0] RVG_AUIPC     = 5'd5;
    localparam logic [4:0] RVG_OP_IMM_32 = 5'd6;
    localparam logic [4:0] RVG_STORE     = 5'd8;
    localparam logic [4:0] RVG_STORE_FP  = 5'd9;
    localparam logic [4:0] RVG_custom_1  = 5'd10;
    localparam logic [4:0] RVG_AMO       = 5'd11;
    localparam logic [4:0] RVG_OP        = 5'd12;
    localparam logic [4:0] RVG_LUI       = 5'd13;
    localparam logic [4:0] RVG_OP_32     = 5'd14;
    localparam logic [4:0] RVG_BRANCH    = 5'd24;
    localparam logic [4:0] RVG_JALR      = 5'd25;
    localparam logic [4:0] RVG_JAL       = 5'd27;
    localparam logic [4:0] RVG_SYSTEM    = 5'd28;

    localparam logic [2:0] MINOR_SET  = 3'd0;
    localparam logic [2:0] MINOR_ADD  = 3'd1;
    localparam logic [2:0] MINOR_READ = 3'd2;

    localparam logic [2:0] LAST_STEP     = 3'd6;
    localparam logic [2:0] STARTUP_EDGES = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic        hid;
        logic [2:0]  minor;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] expected;
    } step_t;

endpackage

// File: rtl/riscv_custom_instr_wrapper_if.sv
// Custom-instruction issue bus: payload out to the accelerator,
// one-cycle-latency result back.
interface riscv_custom_instr_wrapper_if;

    logic        CustomInstr_valid_out;
    logic        CustomInstr_hid_out;
    logic [4:0]  CustomInstr_major_opcode_out;
    logic [2:0]  CustomInstr_minor_opcode_out;
    logic [31:0] CustomInstr_op1_out;
    logic [31:0] CustomInstr_op2_out;
    logic [31:0] CustomInstr_imm_out;
    logic [6:0]  CustomInstr_funct7_out;
    logic [31:0] CustomInstr_result_in;

    modport master (
        output CustomInstr_valid_out,
        output CustomInstr_hid_out,
        output CustomInstr_major_opcode_out,
        output CustomInstr_minor_opcode_out,
        output CustomInstr_op1_out,
        output CustomInstr_op2_out,
        output CustomInstr_imm_out,
        output CustomInstr_funct7_out,
        input  CustomInstr_result_in
    );

    modport slave (
        input  CustomInstr_valid_out,
        input  CustomInstr_hid_out,
        input  CustomInstr_major_opcode_out,
        input  CustomInstr_minor_opcode_out,
        input  CustomInstr_op1_out,
        input  CustomInstr_op2_out,
        input  CustomInstr_imm_out,
        input  CustomInstr_funct7_out,
        output CustomInstr_result_in
    );

endinterface

// File: rtl/riscv_custom_instr_wrapper_step_rom.sv
// Self-test instruction sequence: two harts are loaded, accumulated
// and read back; expected is only meaningful on read steps.
module custom_instr_step_rom
    import RISCVCustomInstrWrapperTypes::*;
(
    input  logic [2:0] idx,
    output step_t      step
);

    always_comb begin
        step = '0;
        unique case (idx)
            3'd0: step = '{1'b0, MINOR_SET,  32'h0000_0010,
                           32'h0000_0000, 32'h0000_0000};
            3'd1: step = '{1'b1, MINOR_SET,  32'h1000_0000,
                           32'h0000_0000, 32'h0000_0000};
            3'd2: step = '{1'b0, MINOR_ADD,  32'h0000_0000,
                           32'h0000_0005, 32'h0000_0000};
            3'd3: step = '{1'b1, MINOR_ADD,  32'h0000_0000,
                           32'hFFFF_FFFF, 32'h0000_0000};
            3'd4: step = '{1'b0, MINOR_ADD,  32'h0000_0000,
                           32'h0000_0007, 32'h0000_0000};
            3'd5: step = '{1'b0, MINOR_READ, 32'h0000_0000,
                           32'h0000_0000, 32'h0000_001C};
            3'd6: step = '{1'b1, MINOR_READ, 32'h0000_0000,
                           32'h0000_0000, 32'h0FFF_FFFF};
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/riscv_custom_instr_wrapper.sv
// Start-queue driven self-test sequencer for a custom RISC-V instruction
// unit; each run issues the step table and leaves one completion token.
module riscv_custom_instr_wrapper
    import RISCVCustomInstrWrapperTypes::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       rst_and_startup_done_out,
    output logic       stall_rate_supported_out,
    input  logic       stall_rate_valid_in,
    input  logic [2:0] stall_rate_in,
    input  logic       StartRISCV_valid_in,
    output logic       StartRISCV_rdy_out,
    input  logic       StartRISCV_rden_in,
    output logic       StartRISCV_empty_out,
    riscv_custom_instr_wrapper_if.master ci
);

    state_t     state, state_nx;
    logic [2:0] step, step_nx;
    logic [2:0] boot_cnt;
    logic       startup_done;
    logic       start_q;
    logic       slot_full;
    logic       test_error;
    logic       push_start, pop_start;
    logic       push_tok, pop_tok;
    logic       issue, capture, mismatch;
    step_t      rom;

    wire unused_stall = ^{stall_rate_valid_in, stall_rate_in};

    custom_instr_step_rom u_rom (
        .idx  (step),
        .step (rom)
    );

    assign startup_done = (boot_cnt == STARTUP_EDGES);

    assign stall_rate_supported_out = 1'b0;
    assign rst_and_startup_done_out = startup_done;
    assign StartRISCV_rdy_out       = startup_done & ~start_q;
    assign StartRISCV_empty_out     = ~slot_full;

    assign push_start = StartRISCV_valid_in & StartRISCV_rdy_out;
    assign pop_tok    = StartRISCV_rden_in & slot_full;
    assign mismatch   = capture &
                        (ci.CustomInstr_result_in != rom.expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_cnt <= '0;
        end else if (!startup_done) begin
            boot_cnt <= boot_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= '0;
            start_q    <= 1'b0;
            slot_full  <= 1'b0;
            test_error <= 1'b0;
        end else begin
            state      <= state_nx;
            step       <= step_nx;
            test_error <= test_error | mismatch;
            if (push_start) begin
                start_q <= 1'b1;
            end else if (pop_start) begin
                start_q <= 1'b0;
            end
            // a simultaneous push and pop leaves the slot occupied
            if (push_tok) begin
                slot_full <= 1'b1;
            end else if (pop_tok) begin
                slot_full <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        step_nx   = step;
        pop_start = 1'b0;
        push_tok  = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_q) begin
                    pop_start = 1'b1;
                    step_nx   = '0;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (rom.minor == MINOR_READ) begin
                    state_nx = CAPTURE;
                end else if (step == LAST_STEP) begin
                    state_nx = DONE;
                end else begin
                    step_nx = step + 3'd1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                if (step == LAST_STEP) begin
                    state_nx = DONE;
                end else begin
                    step_nx  = step + 3'd1;
                    state_nx = ISSUE;
                end
            end
            DONE: begin
                if (!slot_full || pop_tok) begin
                    push_tok = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // payload is zeroed whenever no instruction is being issued
    always_comb begin
        ci.CustomInstr_valid_out        = issue;
        ci.CustomInstr_hid_out          = 1'b0;
        ci.CustomInstr_major_opcode_out = '0;
        ci.CustomInstr_minor_opcode_out = '0;
        ci.CustomInstr_op1_out          = '0;
        ci.CustomInstr_op2_out          = '0;
        ci.CustomInstr_imm_out          = '0;
        ci.CustomInstr_funct7_out       = '0;
        if (issue) begin
            ci.CustomInstr_hid_out          = rom.hid;
            ci.CustomInstr_major_opcode_out = RVG_custom_0;
            ci.CustomInstr_minor_opcode_out = rom.minor;
            ci.CustomInstr_op1_out          = rom.op1;
            ci.CustomInstr_op2_out          = rom.op2;
        end
    end

endmodule

// File: tb/tb_riscv_custom_instr_wrapper.sv
// Directed bench: reference accelerator model, run-scenario table and
// hand sequences for backpressure, output slot and mid-run reset.
module tb_riscv_custom_instr_wrapper;
    import RISCVCustomInstrWrapperTypes::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_o;
    logic       stall_sup;
    logic       stall_v = 1'b0;
    logic [2:0] stall_r = 3'd0;
    logic       start_v = 1'b0;
    logic       rdy;
    logic       rden = 1'b0;
    logic       empty;

    riscv_custom_instr_wrapper_if ci ();

    riscv_custom_instr_wrapper dut (
        .clk                      (clk),
        .rst                      (rst),
        .rst_and_startup_done_out (done_o),
        .stall_rate_supported_out (stall_sup),
        .stall_rate_valid_in      (stall_v),
        .stall_rate_in            (stall_r),
        .StartRISCV_valid_in      (start_v),
        .StartRISCV_rdy_out       (rdy),
        .StartRISCV_rden_in       (rden),
        .StartRISCV_empty_out     (empty),
        .ci                       (ci)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hid;
        logic [2:0]  minor;
        logic [31:0] op1;
        logic [31:0] op2;
    } instr_t;

    typedef struct {
        logic [4:0]  major;
        logic        hid;
        logic [2:0]  minor;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [6:0]  funct7;
    } seen_t;

    typedef struct {
        string name;
        bit    bad_model;
        logic  exp_err;
    } run_vec_t;

    instr_t   exp_tab [7];
    run_vec_t runs [2];
    seen_t    log [$];

    logic [31:0] hart_st [2];
    logic [31:0] res_q = 32'hdeadbeef;
    bit          model_bad = 1'b0;
    int          checks = 0;
    int          failures = 0;

    assign ci.CustomInstr_result_in = res_q;

    // reference accelerator: per-hart register, read result one edge later
    always @(posedge clk) begin
        res_q <= 32'hdeadbeef;
        if (ci.CustomInstr_valid_out) begin
            log.push_back('{ci.CustomInstr_major_opcode_out,
                            ci.CustomInstr_hid_out,
                            ci.CustomInstr_minor_opcode_out,
                            ci.CustomInstr_op1_out,
                            ci.CustomInstr_op2_out,
                            ci.CustomInstr_imm_out,
                            ci.CustomInstr_funct7_out});
            case (ci.CustomInstr_minor_opcode_out)
                3'd0: hart_st[ci.CustomInstr_hid_out] <= ci.CustomInstr_op1_out;
                3'd1: hart_st[ci.CustomInstr_hid_out] <=
                          hart_st[ci.CustomInstr_hid_out] + ci.CustomInstr_op2_out;
                3'd2: if (!model_bad) res_q <= hart_st[ci.CustomInstr_hid_out];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic pulse_rden();
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
    endtask

    task automatic reset_and_boot();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("boot_done_3_edges", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("boot_done_4_edges", 32'(done_o), 32'd1);
        log.delete();
    endtask

    task automatic wait_token(input string name, input int budget);
        int n = 0;
        while (empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_token_timeout"}, 32'(empty), 32'd0);
    endtask

    task automatic check_log(input string name, input int base);
        chk({name, "_count"}, 32'(log.size()), 32'(base + 7));
        for (int i = 0; i < 7; i++) begin
            if (base + i < log.size()) begin
                chk($sformatf("%s_s%0d_major", name, i),
                    32'(log[base+i].major), 32'(RVG_custom_0));
                chk($sformatf("%s_s%0d_hid", name, i),
                    32'(log[base+i].hid), 32'(exp_tab[i].hid));
                chk($sformatf("%s_s%0d_minor", name, i),
                    32'(log[base+i].minor), 32'(exp_tab[i].minor));
                chk($sformatf("%s_s%0d_op1", name, i),
                    log[base+i].op1, exp_tab[i].op1);
                chk($sformatf("%s_s%0d_op2", name, i),
                    log[base+i].op2, exp_tab[i].op2);
                chk($sformatf("%s_s%0d_imm_f7", name, i),
                    log[base+i].imm | 32'(log[base+i].funct7), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0] = '{1'b0, 3'd0, 32'h0000_0010, 32'h0000_0000};
        exp_tab[1] = '{1'b1, 3'd0, 32'h1000_0000, 32'h0000_0000};
        exp_tab[2] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0000_0005};
        exp_tab[3] = '{1'b1, 3'd1, 32'h0000_0000, 32'hFFFF_FFFF};
        exp_tab[4] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0000_0007};
        exp_tab[5] = '{1'b0, 3'd2, 32'h0000_0000, 32'h0000_0000};
        exp_tab[6] = '{1'b1, 3'd2, 32'h0000_0000, 32'h0000_0000};
        runs[0] = '{"run_good", 1'b0, 1'b0};
        runs[1] = '{"run_badres", 1'b1, 1'b1};
        hart_st[0] = '0;
        hart_st[1] = '0;

        // reset held 10 cycles, stall inputs toggled to show they are ignored
        rst = 1'b1;
        stall_v = 1'b1;
        stall_r = 3'd5;
        repeat (10) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(ci.CustomInstr_valid_out), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_payload", ci.CustomInstr_op1_out | ci.CustomInstr_op2_out
            | 32'(ci.CustomInstr_major_opcode_out), 32'd0);
        chk("stall_sup", 32'(stall_sup), 32'd0);

        // start pushed during startup (rdy low) must be dropped
        rst = 1'b0;
        pulse_start();
        chk("boot_done_1_edge", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk);
        chk("boot_done_3_edge", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("boot_done_4_edge", 32'(done_o), 32'd1);
        chk("boot_rdy", 32'(rdy), 32'd1);
        repeat (20) @(negedge clk);
        chk("drop_no_instr", 32'(log.size()), 32'd0);
        chk("drop_empty", 32'(empty), 32'd1);
        chk("drop_state", 32'(dut.state), 32'(IDLE));

        pulse_rden();
        chk("rden_empty_noop", 32'(empty), 32'd1);
        stall_v = 1'b0;
        stall_r = 3'd0;

        for (int r = 0; r < 2; r++) begin
            reset_and_boot();
            model_bad = runs[r].bad_model;
            pulse_start();
            wait_token(runs[r].name, 100);
            check_log(runs[r].name, 0);
            chk({runs[r].name, "_test_error"}, 32'(dut.test_error),
                32'(runs[r].exp_err));
            pulse_rden();
            chk({runs[r].name, "_popped"}, 32'(empty), 32'd1);
        end
        model_bad = 1'b0;

        // second start queued mid-run; token left unread
        reset_and_boot();
        pulse_start();
        repeat (3) @(negedge clk);
        chk("bp_rdy_during_run", 32'(rdy), 32'd1);
        pulse_start();
        chk("bp_rdy_queued", 32'(rdy), 32'd0);
        wait_token("bp_run1", 100);
        repeat (30) @(negedge clk);
        check_log("bp_run2", 7);
        chk("bp_wait_state", 32'(dut.state), 32'(DONE));
        chk("bp_wait_empty", 32'(empty), 32'd0);
        pulse_rden();
        chk("bp_pushpop_full", 32'(empty), 32'd0);
        chk("bp_pushpop_idle", 32'(dut.state), 32'(IDLE));
        pulse_rden();
        chk("bp_final_empty", 32'(empty), 32'd1);
        chk("bp_test_error", 32'(dut.test_error), 32'd0);

        // reset asserted while step 3 is on the bus
        reset_and_boot();
        pulse_start();
        for (int n = 0; n < 50 && log.size() < 3; n++) @(negedge clk);
        chk("mid_reached_step3", 32'(log.size()), 32'd3);
        chk("mid_valid_before", 32'(ci.CustomInstr_valid_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_valid_async", 32'(ci.CustomInstr_valid_out), 32'd0);
        chk("mid_op2_async", ci.CustomInstr_op2_out, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_no_token", 32'(empty), 32'd1);
        chk("mid_no_more_instr", 32'(log.size()), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
